// File: rtl/qea_ctrl_pkg.sv
// Shared types and constants for the QEA run controller.
package qea_ctrl_pkg;

    localparam int ROW_IDX_W = 16 + 1;
    localparam logic [63:0] AMP_ONE = 64'h40000000_00000000;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_CTX,
        ST_INIT_ST,
        ST_START,
        ST_RUN,
        ST_READ_ISSUE,
        ST_READ_WAIT,
        ST_READ_HOLD,
        ST_DONE
    } run_state_e;

endpackage

// File: rtl/qea_readout_reg.sv
// One-entry output register for the state-vector readout stream.
// valid_o rises on capture_i and holds data_o stable until valid_o && ready_i.
module qea_readout_reg #(
    parameter int W = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         capture_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (capture_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/qea_run_ctrl.sv
// Host-side sequencer: loads QEA context and initial state, runs it with a
// cycle counter and watchdog, then streams the final state vector out.
module qea_run_ctrl
    import qea_ctrl_pkg::*;
#(
    parameter int PE_NUM                  = 4,
    parameter int STATE_DATA_WIDTH        = 64,
    parameter int STATE_ADDR_WIDTH        = ROW_IDX_W - 1,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int RD_LAT                  = 1,
    parameter int TIMEOUT_CYCLES          = 1000000,
    parameter int CYC_W                   = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_go,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH:0]     i_ins_num,
    input  logic                                 i_ctx_valid,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
    output logic                                 o_ctx_ready,
    output logic                                 o_qea_start,
    output logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num,
    output logic                                 o_qea_ctx_en,
    output logic                                 o_qea_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_qea_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_qea_ctx_data,
    output logic                                 o_qea_state_ena,
    output logic                                 o_qea_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]          o_qea_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_qea_state_dina,
    input  logic                                 i_qea_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_state_dout,
    output logic                                 o_rd_valid,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_rd_data,
    input  logic                                 i_rd_ready,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic                                 o_error,
    output logic [CYC_W-1:0]                     o_exec_cycles,
    output run_state_e                           o_dbg_state
);

    localparam int RW  = STATE_ADDR_WIDTH + 1;
    localparam int IW  = GATE_CONTEXT_ADDR_WIDTH + 1;
    localparam int MQW = MAX_QBIT_WIDTH;
    localparam int ROW_BITS = PE_NUM * STATE_DATA_WIDTH;

    run_state_e          state_q, state_d;
    logic [MQW-1:0]      qbit_q, qbit_d;
    logic [IW-1:0]       ins_q, ins_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [RW-1:0]       rows_q, rows_d;
    logic [RW-1:0]       row_q, row_d;
    logic [2:0]          lat_q, lat_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic                err_q, err_d;

    logic                params_bad;
    logic [CYC_W-1:0]    cyc_inc;
    logic                capture;

    assign params_bad = (32'(i_qbit_num) < 32'd2)
                     || (32'(i_qbit_num) > 32'(STATE_ADDR_WIDTH + 2))
                     || (i_ins_num == '0)
                     || (33'(i_ins_num) > (33'd1 << GATE_CONTEXT_ADDR_WIDTH));

    assign cyc_inc = (cyc_q == '1) ? cyc_q : cyc_q + CYC_W'(1);

    always_comb begin
        state_d = state_q;
        qbit_d  = qbit_q;
        ins_d   = ins_q;
        idx_d   = idx_q;
        rows_d  = rows_q;
        row_d   = row_q;
        lat_d   = lat_q;
        cyc_d   = cyc_q;
        err_d   = err_q;
        capture = 1'b0;

        o_ctx_ready       = 1'b0;
        o_qea_start       = 1'b0;
        o_qea_ctx_en      = 1'b0;
        o_qea_ctx_wea     = 1'b0;
        o_qea_ctx_addr    = '0;
        o_qea_ctx_data    = '0;
        o_qea_state_ena   = 1'b0;
        o_qea_state_wea   = 1'b0;
        o_qea_state_addra = '0;
        o_qea_state_dina  = '0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_go) begin
                    err_d = 1'b0;
                    cyc_d = '0;
                    if (params_bad) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        qbit_d  = i_qbit_num;
                        ins_d   = i_ins_num;
                        rows_d  = RW'(1) << (i_qbit_num - MQW'(2));
                        idx_d   = '0;
                        row_d   = '0;
                        state_d = ST_LOAD_CTX;
                    end
                end
            end
            ST_LOAD_CTX: begin
                o_ctx_ready = 1'b1;
                if (i_ctx_valid) begin
                    o_qea_ctx_en   = 1'b1;
                    o_qea_ctx_wea  = 1'b1;
                    o_qea_ctx_addr = idx_q[GATE_CONTEXT_ADDR_WIDTH-1:0];
                    o_qea_ctx_data = i_ctx_data;
                    if (idx_q == ins_q - IW'(1)) begin
                        row_d   = '0;
                        state_d = ST_INIT_ST;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            ST_INIT_ST: begin
                o_qea_state_ena   = 1'b1;
                o_qea_state_wea   = 1'b1;
                o_qea_state_addra = row_q[STATE_ADDR_WIDTH-1:0];
                if (row_q == '0) begin
                    o_qea_state_dina[ROW_BITS-1 -: STATE_DATA_WIDTH] = STATE_DATA_WIDTH'(AMP_ONE);
                end
                if (row_q == rows_q - RW'(1)) begin
                    row_d   = '0;
                    state_d = ST_START;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            ST_START: begin
                o_qea_start = 1'b1;
                cyc_d       = '0;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                cyc_d = cyc_inc;
                // The first two RUN cycles may still see the previous run's complete level.
                if (i_qea_complete && (cyc_q >= CYC_W'(2))) begin
                    row_d   = '0;
                    state_d = ST_READ_ISSUE;
                end else if (cyc_inc >= CYC_W'(TIMEOUT_CYCLES)) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_READ_ISSUE: begin
                o_qea_state_ena   = 1'b1;
                o_qea_state_addra = row_q[STATE_ADDR_WIDTH-1:0];
                lat_d             = '0;
                state_d           = ST_READ_WAIT;
            end
            ST_READ_WAIT: begin
                if (lat_q == 3'(RD_LAT - 1)) begin
                    capture = 1'b1;
                    state_d = ST_READ_HOLD;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            ST_READ_HOLD: begin
                if (o_rd_valid && i_rd_ready) begin
                    if (row_q == rows_q - RW'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        row_d   = row_q + RW'(1);
                        state_d = ST_READ_ISSUE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Strobes drop in the reset cycle itself, not one edge later.
        if (rst) begin
            capture         = 1'b0;
            o_ctx_ready     = 1'b0;
            o_qea_start     = 1'b0;
            o_qea_ctx_en    = 1'b0;
            o_qea_ctx_wea   = 1'b0;
            o_qea_ctx_addr  = '0;
            o_qea_ctx_data  = '0;
            o_qea_state_ena = 1'b0;
            o_qea_state_wea = 1'b0;
            o_qea_state_addra = '0;
            o_qea_state_dina  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            qbit_q  <= '0;
            ins_q   <= '0;
            idx_q   <= '0;
            rows_q  <= '0;
            row_q   <= '0;
            lat_q   <= '0;
            cyc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            qbit_q  <= qbit_d;
            ins_q   <= ins_d;
            idx_q   <= idx_d;
            rows_q  <= rows_d;
            row_q   <= row_d;
            lat_q   <= lat_d;
            cyc_q   <= cyc_d;
            err_q   <= err_d;
        end
    end

    qea_readout_reg #(.W(ROW_BITS)) u_readout (
        .clk       (clk),
        .rst       (rst),
        .capture_i (capture),
        .data_i    (i_qea_state_dout),
        .ready_i   (i_rd_ready),
        .valid_o   (o_rd_valid),
        .data_o    (o_rd_data)
    );

    assign o_qea_qbit_num = qbit_q;
    assign o_busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign o_done         = (state_q == ST_DONE);
    assign o_error        = err_q;
    assign o_exec_cycles  = cyc_q;
    assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_qea_run_ctrl.sv
// Bench for qea_run_ctrl with a stub QEA (state RAM model + complete timing).
module tb_qea_run_ctrl;
    import qea_ctrl_pkg::*;

    localparam logic [63:0] AMP = 64'h4000_0000_0000_0000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_go = 1'b0;
    logic [5:0]   i_qbit_num = '0;
    logic [16:0]  i_ins_num = '0;
    logic         i_ctx_valid = 1'b0;
    logic [63:0]  i_ctx_data = '0;
    logic         o_ctx_ready, o_qea_start;
    logic [5:0]   o_qea_qbit_num;
    logic         o_qea_ctx_en, o_qea_ctx_wea;
    logic [15:0]  o_qea_ctx_addr;
    logic [63:0]  o_qea_ctx_data;
    logic         o_qea_state_ena, o_qea_state_wea;
    logic [15:0]  o_qea_state_addra;
    logic [255:0] o_qea_state_dina;
    logic         i_qea_complete = 1'b0;
    logic [255:0] i_qea_state_dout = '0;
    logic         o_rd_valid;
    logic [255:0] o_rd_data;
    logic         i_rd_ready = 1'b1;
    logic         o_busy, o_done, o_error;
    logic [31:0]  o_exec_cycles;
    run_state_e   o_dbg_state;

    always #5 clk = ~clk;

    qea_run_ctrl #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .i_go(i_go), .i_qbit_num(i_qbit_num), .i_ins_num(i_ins_num),
        .i_ctx_valid(i_ctx_valid), .i_ctx_data(i_ctx_data), .o_ctx_ready(o_ctx_ready),
        .o_qea_start(o_qea_start), .o_qea_qbit_num(o_qea_qbit_num),
        .o_qea_ctx_en(o_qea_ctx_en), .o_qea_ctx_wea(o_qea_ctx_wea),
        .o_qea_ctx_addr(o_qea_ctx_addr), .o_qea_ctx_data(o_qea_ctx_data),
        .o_qea_state_ena(o_qea_state_ena), .o_qea_state_wea(o_qea_state_wea),
        .o_qea_state_addra(o_qea_state_addra), .o_qea_state_dina(o_qea_state_dina),
        .i_qea_complete(i_qea_complete), .i_qea_state_dout(i_qea_state_dout),
        .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .i_rd_ready(i_rd_ready),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
        .o_exec_cycles(o_exec_cycles), .o_dbg_state(o_dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [79:0]  ctx_exp_q[$];
    logic [271:0] st_exp_q[$];
    logic [255:0] rd_exp_q[$];

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // ---------------- monitor ----------------
    int ready_cycles = 0;
    int start_cnt = 0;
    int strobe_cnt = 0;

    always @(negedge clk) begin
        if (o_ctx_ready) ready_cycles++;
        if (o_qea_start) start_cnt++;
        if (o_qea_ctx_en || o_qea_state_ena) strobe_cnt++;
        if (o_qea_ctx_en && o_qea_state_ena) note_fail("port_overlap");
        if (o_qea_ctx_en) begin
            check("ctx_en_gap", i_ctx_valid, 1);
            if (ctx_exp_q.size() == 0) note_fail("ctx_write_unexpected");
            else check("ctx_write", {o_qea_ctx_wea, o_qea_ctx_addr, o_qea_ctx_data},
                       {1'b1, ctx_exp_q.pop_front()});
        end
        if (o_qea_state_ena && o_qea_state_wea) begin
            if (st_exp_q.size() == 0) note_fail("state_write_unexpected");
            else check("state_write", {o_qea_state_addra, o_qea_state_dina}, st_exp_q.pop_front());
        end
        if (o_rd_valid && i_rd_ready) begin
            if (rd_exp_q.size() == 0) note_fail("rd_row_unexpected");
            else check("rd_row", o_rd_data, rd_exp_q.pop_front());
        end
    end

    // ---------------- stub QEA ----------------
    logic         s_ena = 1'b0, s_wea = 1'b0, s_start = 1'b0;
    logic [15:0]  s_addr = '0;
    logic [255:0] s_din = '0;
    logic [255:0] st_mem [16];
    int  cmpl_cnt = 0;
    bit  run_active = 1'b0;
    int  cmpl_delay = 37;
    int  cur_rows = 1;

    always @(negedge clk) begin
        s_ena   = o_qea_state_ena;
        s_wea   = o_qea_state_wea;
        s_addr  = o_qea_state_addra;
        s_din   = o_qea_state_dina;
        s_start = o_qea_start;
    end

    always @(posedge clk) begin
        #1;
        if (s_ena && s_wea) st_mem[s_addr[3:0]] = s_din;
        if (s_ena && !s_wea) i_qea_state_dout = st_mem[s_addr[3:0]];
        if (s_start) begin
            cmpl_cnt = 0;
            run_active = 1'b1;
        end else if (run_active) begin
            cmpl_cnt++;
            if (cmpl_cnt == 2) i_qea_complete = 1'b0;
            if (cmpl_delay > 0 && cmpl_cnt == cmpl_delay - 1) begin
                for (int r = 0; r < cur_rows; r++) begin
                    st_mem[r] = rand256();
                    rd_exp_q.push_back(st_mem[r]);
                end
                i_qea_complete = 1'b1;
                run_active = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic go(input int q, input int ins);
        i_go = 1'b1;
        i_qbit_num = 6'(q);
        i_ins_num = 17'(ins);
        @(posedge clk); #1;
        i_go = 1'b0;
    endtask

    task automatic send_ctx(input int n, input bit gaps);
        logic [63:0] d;
        for (int k = 0; k < n; k++) begin
            d = {$urandom, $urandom};
            i_ctx_valid = 1'b1;
            i_ctx_data = d;
            ctx_exp_q.push_back({16'(k), d});
            @(posedge clk); #1;
            if (gaps) begin
                i_ctx_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        i_ctx_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!o_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!o_done) note_fail("done_timeout");
    endtask

    task automatic do_run(input int q, input int ins, input bit gaps, input int delay,
                          input bit stall, input int exp_exec, input bit exp_err);
        logic [255:0] row0;
        int n;
        row0 = '0;
        row0[255 -: 64] = AMP;
        cur_rows = 1 << (q - 2);
        cmpl_delay = delay;
        for (int r = 0; r < cur_rows; r++)
            st_exp_q.push_back({16'(r), (r == 0) ? row0 : 256'd0});
        i_rd_ready = !stall;
        ready_cycles = 0;
        start_cnt = 0;
        go(q, ins);
        send_ctx(ins, gaps);
        if (stall) begin
            n = 0;
            while (!o_rd_valid && n < 1000) begin
                @(negedge clk);
                n++;
            end
            if (!o_rd_valid) note_fail("rd_valid_timeout");
            else begin
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    check("rd_stall_valid", o_rd_valid, 1);
                    check("rd_stall_data", o_rd_data, (rd_exp_q.size() > 0) ? rd_exp_q[0] : 256'd0);
                end
            end
            @(posedge clk); #1;
            i_rd_ready = 1'b1;
        end
        wait_done(5000);
        @(negedge clk);
        check("run_done", {o_done, o_busy, o_dbg_state}, {1'b1, 1'b0, ST_DONE});
        check("run_error", o_error, exp_err);
        check("run_exec_cycles", o_exec_cycles, exp_exec);
        check("run_start_pulses", start_cnt, 1);
        check("run_ready_cycles", ready_cycles, gaps ? 2 * ins - 1 : ins);
        check("run_qbit_out", o_qea_qbit_num, q);
        check("run_queues_empty", {32'(ctx_exp_q.size()), 32'(st_exp_q.size()), 32'(rd_exp_q.size())}, 0);
    endtask

    // ---------------- parameter-check table ----------------
    typedef struct {
        int q;
        int ins;
        bit bad;
    } pchk_t;
    pchk_t tbl[8];

    initial begin
        int s0;
        tbl[0] = '{q: 0,  ins: 4,     bad: 1'b1};
        tbl[1] = '{q: 1,  ins: 4,     bad: 1'b1};
        tbl[2] = '{q: 2,  ins: 4,     bad: 1'b0};
        tbl[3] = '{q: 18, ins: 4,     bad: 1'b0};
        tbl[4] = '{q: 19, ins: 4,     bad: 1'b1};
        tbl[5] = '{q: 3,  ins: 0,     bad: 1'b1};
        tbl[6] = '{q: 3,  ins: 65536, bad: 1'b0};
        tbl[7] = '{q: 3,  ins: 65537, bad: 1'b1};

        // reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", o_dbg_state, ST_IDLE);
        check("reset_outputs", {o_ctx_ready, o_qea_start, o_qea_qbit_num, o_qea_ctx_en, o_qea_ctx_wea,
                                o_qea_state_ena, o_qea_state_wea, o_rd_valid, o_busy, o_done,
                                o_error, o_exec_cycles}, 0);
        check("reset_rd_data", o_rd_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // gapless 81-word load, 2 rows
        do_run(3, 81, 1'b0, 50, 1'b0, 50, 1'b0);
        // gapped load, 5 words; complete still high from the previous run
        do_run(2, 5, 1'b1, 20, 1'b0, 20, 1'b0);
        // complete after 37 cycles, readout stalled for 10 cycles
        do_run(3, 4, 1'b0, 37, 1'b1, 37, 1'b0);

        // parameter checks
        for (int i = 0; i < 8; i++) begin
            s0 = strobe_cnt;
            go(tbl[i].q, tbl[i].ins);
            @(negedge clk);
            check("pchk_error", o_error, tbl[i].bad);
            check("pchk_done_busy", {o_done, o_busy}, {tbl[i].bad, !tbl[i].bad});
            check("pchk_exec_cleared", o_exec_cycles, 0);
            if (tbl[i].bad) begin
                check("pchk_no_strobe", strobe_cnt, s0);
            end else begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
            end
        end

        // stale complete held through START, 4 rows
        do_run(4, 2, 1'b0, 37, 1'b0, 37, 1'b0);
        // watchdog: complete never asserted
        do_run(3, 2, 1'b0, 0, 1'b0, 100, 1'b1);

        // reset while loading context at word 20
        cur_rows = 2;
        cmpl_delay = 37;
        go(3, 40);
        send_ctx(20, 1'b0);
        i_ctx_valid = 1'b1;
        i_ctx_data = {$urandom, $urandom};
        rst = 1'b1;
        @(negedge clk);
        check("rst_ctx_strobe_drop", {o_qea_ctx_en, o_qea_ctx_wea, o_ctx_ready}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        i_ctx_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_state", o_dbg_state, ST_IDLE);
        check("rst_mid_outputs", {o_ctx_ready, o_qea_start, o_qea_qbit_num, o_qea_ctx_en,
                                  o_qea_state_ena, o_rd_valid, o_busy, o_done, o_error,
                                  o_exec_cycles}, 0);
        check("rst_mid_ctx_count", ctx_exp_q.size(), 0);
        do_run(2, 3, 1'b0, 10, 1'b0, 10, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        note_fail("global_timeout");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
